// File: rtl/spi_pkg.sv
// Shared definitions for the SD card SPI master.
// Contents: register word addresses, STATUS/CTRL bit positions and the
// transfer FSM state encoding. No ports; imported by sdcard_spi_master.
package spi_pkg;

   // Register word addresses (addr[1:0])
   localparam logic [1:0] SPI_DATA   = 2'd0;
   localparam logic [1:0] SPI_STATUS = 2'd1;
   localparam logic [1:0] SPI_DIV    = 2'd2;
   localparam logic [1:0] SPI_CTRL   = 2'd3;

   // STATUS bit positions
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_WCOL = 2;

   // CTRL bit positions
   localparam int CTRL_CSEN = 0;
   localparam int CTRL_IE   = 1;

   // Transfer FSM: LOW/HIGH are the two SCK half-periods of a bit
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } spi_state_e;

endpackage

// File: rtl/sdcard_spi_master.sv
// Byte-wide SPI master (mode 0) for the SD card, as a peripheral-bus slave.
// Ports:
//   clk, nrst          system clock, synchronous active-low reset
//   data_out[31:0]     combinational read data (0 unless nrst && cs && oe)
//   data_in[31:0]      write data (only low byte used)
//   addr[1:0]          register select: DATA, STATUS, DIV, CTRL
//   cs, oe, wstrb[3:0] block select, read strobe, byte strobes (wstrb[0] only)
//   sdcard_sck/mosi    SPI clock / data out to the PORTB mux
//   sdcard_miso        SPI data in from PORTB pin 3
//   sdcard_cs_n        card chip-select, active low (~CTRL.CSEN)
//   spi_irq            IE && DONE
// Bus handshake: a write is accepted on any rising edge where cs && wstrb[0];
// a read is combinational while cs && oe, and a DATA read clears DONE on the
// edge that ends the read cycle. There is no wait state or ready signal.
module sdcard_spi_master
   import spi_pkg::*;
#(
   parameter int DIV_WIDTH = 8
) (
   input  logic        clk,
   input  logic        nrst,
   output logic [31:0] data_out,
   input  logic [31:0] data_in,
   input  logic [1:0]  addr,
   input  logic        cs,
   input  logic        oe,
   input  logic [3:0]  wstrb,
   output logic        sdcard_sck,
   output logic        sdcard_mosi,
   input  logic        sdcard_miso,
   output logic        sdcard_cs_n,
   output logic        spi_irq
);

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   spi_state_e           state_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] div_cnt_q;
   logic [7:0]           tx_sr_q;
   logic [7:0]           rx_sr_q;
   logic [7:0]           rx_data_q;
   logic [2:0]           bit_cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 wcol_q;
   logic                 csen_q;
   logic                 ie_q;
   logic                 cs_n_q;
   logic                 sck_q;
   logic                 mosi_q;

   logic wr_en, rd_en;
   logic data_wr, stat_wr, div_wr, ctrl_wr, data_rd;
   logic unused_bits;

   assign wr_en   = cs & wstrb[0];
   assign rd_en   = cs & oe;
   assign data_wr = wr_en && (addr == SPI_DATA);
   assign stat_wr = wr_en && (addr == SPI_STATUS);
   assign div_wr  = wr_en && (addr == SPI_DIV);
   assign ctrl_wr = wr_en && (addr == SPI_CTRL);
   assign data_rd = rd_en && (addr == SPI_DATA);

   assign unused_bits = ^{data_in[31:8], wstrb[3:1]};

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         div_q     <= '1;
         div_cnt_q <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wcol_q    <= 1'b0;
         csen_q    <= 1'b0;
         ie_q      <= 1'b0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b1;
      end else begin
         // DIV updates only the reload value; a running half-period
         // finishes on div_cnt_q.
         if (div_wr) div_q <= data_in[DIV_WIDTH-1:0];
         if (ctrl_wr) begin
            csen_q <= data_in[CTRL_CSEN];
            ie_q   <= data_in[CTRL_IE];
            cs_n_q <= ~data_in[CTRL_CSEN];
         end
         if (stat_wr && data_in[STAT_WCOL]) wcol_q <= 1'b0;
         if (data_wr && busy_q) wcol_q <= 1'b1;
         // Clear first; the FSM's completion assignment below overrides it.
         if (data_rd || (stat_wr && data_in[STAT_DONE])) done_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               sck_q  <= 1'b0;
               mosi_q <= 1'b1;
               if (data_wr) begin
                  tx_sr_q   <= data_in[7:0];
                  mosi_q    <= data_in[7];
                  bit_cnt_q <= '0;
                  div_cnt_q <= div_q;
                  busy_q    <= 1'b1;
                  state_q   <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (div_cnt_q != '0) begin
                  div_cnt_q <= div_cnt_q - DIV_ONE;
               end else begin
                  sck_q     <= 1'b1;
                  rx_sr_q   <= {rx_sr_q[6:0], sdcard_miso};
                  div_cnt_q <= div_q;
                  state_q   <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (div_cnt_q != '0) begin
                  div_cnt_q <= div_cnt_q - DIV_ONE;
               end else if (bit_cnt_q != 3'd7) begin
                  sck_q     <= 1'b0;
                  tx_sr_q   <= {tx_sr_q[6:0], 1'b0};
                  mosi_q    <= tx_sr_q[6];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  div_cnt_q <= div_q;
                  state_q   <= ST_LOW;
               end else begin
                  sck_q     <= 1'b0;
                  mosi_q    <= 1'b1;
                  rx_data_q <= rx_sr_q;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Combinational read mux
   always_comb begin
      logic [31:0] rd_word;
      logic [31:0] div_word;
      div_word                  = '0;
      div_word[DIV_WIDTH-1:0]   = div_q;
      rd_word                   = '0;
      case (addr)
         SPI_DATA:   rd_word[7:0] = rx_data_q;
         SPI_STATUS: begin
            rd_word[STAT_BUSY] = busy_q;
            rd_word[STAT_DONE] = done_q;
            rd_word[STAT_WCOL] = wcol_q;
         end
         SPI_DIV:    rd_word = div_word;
         SPI_CTRL: begin
            rd_word[CTRL_CSEN] = csen_q;
            rd_word[CTRL_IE]   = ie_q;
         end
         default:    rd_word = '0;
      endcase
      data_out = (nrst && rd_en) ? rd_word : 32'h0;
   end

   assign sdcard_sck  = sck_q;
   assign sdcard_mosi = mosi_q;
   assign sdcard_cs_n = cs_n_q;
   assign spi_irq     = ie_q & done_q;

endmodule

// File: tb/tb_sdcard_spi_master.sv
module tb_sdcard_spi_master;
   import spi_pkg::*;

   logic        clk;
   logic        nrst;
   logic [31:0] data_out;
   logic [31:0] data_in;
   logic [1:0]  addr;
   logic        cs;
   logic        oe;
   logic [3:0]  wstrb;
   logic        sdcard_sck;
   logic        sdcard_mosi;
   logic        sdcard_miso;
   logic        sdcard_cs_n;
   logic        spi_irq;

   logic loop_en;
   logic miso_val;

   int checks;
   int errors;
   int cyc;

   logic [7:0] exp_q[$];
   int         rise_cyc[$];
   logic       rise_mosi[$];
   logic       prev_sck;

   typedef struct {
      logic [7:0] tx;
      int         div;
      logic       loop;
      logic       miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   sdcard_spi_master #(.DIV_WIDTH(8)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .data_out    (data_out),
      .data_in     (data_in),
      .addr        (addr),
      .cs          (cs),
      .oe          (oe),
      .wstrb       (wstrb),
      .sdcard_sck  (sdcard_sck),
      .sdcard_mosi (sdcard_mosi),
      .sdcard_miso (sdcard_miso),
      .sdcard_cs_n (sdcard_cs_n),
      .spi_irq     (spi_irq)
   );

   assign sdcard_miso = loop_en ? sdcard_mosi : miso_val;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SCK rising-edge monitor, sampled mid-cycle
   initial prev_sck = 1'b0;
   always @(negedge clk) begin
      if (sdcard_sck && !prev_sck) begin
         rise_cyc.push_back(cyc);
         rise_mosi.push_back(sdcard_mosi);
      end
      prev_sck = sdcard_sck;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      errors = errors + 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      addr    = a;
      data_in = d;
      cs      = 1'b1;
      wstrb   = 4'h1;
      @(posedge clk);
      #1;
      cs      = 1'b0;
      wstrb   = 4'h0;
      data_in = 32'h0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      cs   = 1'b1;
      oe   = 1'b1;
      #1;
      d = data_out;
      @(posedge clk);
      #1;
      cs = 1'b0;
      oe = 1'b0;
   endtask

   // Poll STATUS once per cycle until DONE; n = edges after the write edge
   task automatic wait_done(input int bound, output int n, output logic [31:0] s);
      bit seen;
      seen = 0;
      n    = 0;
      while (!seen && n <= bound) begin
         rd(SPI_STATUS, s);
         if (s[STAT_DONE]) seen = 1;
         else n = n + 1;
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard: pop expected RX byte and compare with DATA read
   task automatic sb_check_rx(input string name);
      logic [31:0] r;
      rd(SPI_DATA, r);
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         check(name, r, {24'h0, exp_q.pop_front()});
      end
   endtask

   task automatic run_xfer(input logic [7:0] tx, input int div);
      int          n;
      int          w_cyc;
      int          bad;
      logic [31:0] s;
      logic [7:0]  mb;
      rise_cyc.delete();
      rise_mosi.delete();
      wr(SPI_DATA, {24'h0, tx});
      w_cyc = cyc;
      rd(SPI_STATUS, s);
      check("busy_after_write", {31'h0, s[STAT_BUSY]}, 32'd1);
      wait_done(16 * (div + 1) + 8, n, s);
      check("done_latency", n + 1, 16 * (div + 1));
      check("busy_at_done", {31'h0, s[STAT_BUSY]}, 32'd0);
      check("sck_rise_count", rise_cyc.size(), 8);
      if (rise_cyc.size() == 8) begin
         check("first_rise", rise_cyc[0] - w_cyc, div + 1);
         bad = 0;
         for (int i = 1; i < 8; i++)
            if (rise_cyc[i] - rise_cyc[i-1] != 2 * (div + 1)) bad = bad + 1;
         check("rise_spacing", bad, 0);
         mb = '0;
         for (int i = 0; i < 8; i++) mb[7-i] = rise_mosi[i];
         check("mosi_bits", {24'h0, mb}, {24'h0, tx});
      end
      check("mosi_idle", {31'h0, sdcard_mosi}, 32'd1);
      check("sck_idle", {31'h0, sdcard_sck}, 32'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [31:0] r;
      int          n;
      logic [7:0]  tx;
      int          dv;

      checks   = 0;
      errors   = 0;
      nrst     = 1'b0;
      data_in  = 32'h0;
      addr     = 2'd0;
      cs       = 1'b0;
      oe       = 1'b0;
      wstrb    = 4'h0;
      loop_en  = 1'b1;
      miso_val = 1'b0;

      vecs[0] = '{8'hA5, 1, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h3C, 0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{8'hC3, 2, 1'b0, 1'b1, 8'hFF};
      vecs[3] = '{8'h5A, 0, 1'b1, 1'b0, 8'h5A};
      vecs[4] = '{8'h01, 1, 1'b1, 1'b0, 8'h01};

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_sck", {31'h0, sdcard_sck}, 32'd0);
      check("rst_mosi", {31'h0, sdcard_mosi}, 32'd1);
      check("rst_cs_n", {31'h0, sdcard_cs_n}, 32'd1);
      check("rst_irq", {31'h0, spi_irq}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      rd(SPI_STATUS, r); check("rst_status", r, 32'h00);
      rd(SPI_DIV, r);    check("rst_div", r, 32'hFF);
      rd(SPI_CTRL, r);   check("rst_ctrl", r, 32'h00);
      rd(SPI_DATA, r);   check("rst_data", r, 32'h00);

      // Table-driven transfers
      for (int i = 0; i < 5; i++) begin
         wr(SPI_DIV, 32'(vecs[i].div));
         loop_en  = vecs[i].loop;
         miso_val = vecs[i].miso;
         exp_q.push_back(vecs[i].exp_rx);
         run_xfer(vecs[i].tx, vecs[i].div);
         sb_check_rx("rx_data");
         rd(SPI_STATUS, r);
         check("done_cleared_by_read", {31'h0, r[STAT_DONE]}, 32'd0);
      end

      // Random loopback transfers
      loop_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx = 8'($urandom_range(0, 255));
         dv = $urandom_range(0, 3);
         wr(SPI_DIV, 32'(dv));
         exp_q.push_back(tx);
         run_xfer(tx, dv);
         sb_check_rx("rx_rand");
      end

      // Collision: second write while busy is dropped
      wr(SPI_DIV, 32'd1);
      wr(SPI_DATA, 32'h11);
      exp_q.push_back(8'h11);
      wr(SPI_DATA, 32'h22);
      wait_done(40, n, r);
      check("wcol_set", {31'h0, r[STAT_WCOL]}, 32'd1);
      sb_check_rx("rx_collision");
      wr(SPI_STATUS, 32'h04);
      rd(SPI_STATUS, r);
      check("wcol_cleared", r, 32'h00);

      // IRQ and chip-select
      wr(SPI_CTRL, 32'h03);
      check("cs_n_enabled", {31'h0, sdcard_cs_n}, 32'd0);
      wr(SPI_DATA, 32'h96);
      exp_q.push_back(8'h96);
      wait_done(40, n, r);
      check("irq_set", {31'h0, spi_irq}, 32'd1);
      wr(SPI_STATUS, 32'h02);
      check("irq_cleared", {31'h0, spi_irq}, 32'd0);
      sb_check_rx("rx_irq");
      wr(SPI_CTRL, 32'h00);
      check("cs_n_disabled", {31'h0, sdcard_cs_n}, 32'd1);

      // Reset in the middle of a transfer
      wr(SPI_DIV, 32'd3);
      wr(SPI_CTRL, 32'h03);
      wr(SPI_DATA, 32'hF0);
      repeat (19) @(posedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_sck", {31'h0, sdcard_sck}, 32'd0);
      check("mrst_mosi", {31'h0, sdcard_mosi}, 32'd1);
      check("mrst_cs_n", {31'h0, sdcard_cs_n}, 32'd1);
      check("mrst_irq", {31'h0, spi_irq}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      rd(SPI_STATUS, r); check("mrst_status", r, 32'h00);
      rd(SPI_DIV, r);    check("mrst_div", r, 32'hFF);
      repeat (80) @(posedge clk);
      rd(SPI_STATUS, r); check("mrst_no_done", r, 32'h00);

      check("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
